// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: operand width, ALU control
// codes, buffer occupancy states and the buffered result record.
package alu_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
  } alu_entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath.
//   alu_control : 3-bit operation code
//   src_a/src_b : operands
//   result_c    : operation result (0 for undefined codes)
//   illegal_c   : asserted for undefined codes 101..111
module alu_core
  import alu_pkg::*;
(
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result_c,
  output logic             illegal_c
);

  // Operation select; undefined codes produce a zero result flagged illegal
  always_comb begin
    result_c  = '0;
    illegal_c = 1'b0;
    case (alu_control)
      ALU_ADD: result_c = src_a + src_b;
      ALU_SUB: result_c = src_a - src_b;
      ALU_AND: result_c = src_a & src_b;
      ALU_OR:  result_c = src_a | src_b;
      ALU_SLT: result_c = WIDTH'($signed(src_a) < $signed(src_b));
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry output buffer.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake (in_ready depends on state only)
//   alu_control/src_a/b   : operation sampled on accept
//   out_valid/out_ready   : downstream handshake
//   result/zero/illegal   : head entry; hold last popped value when empty
module alu_exec_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  occ_state_t       state_q, state_d;
  logic             head_q, head_d;
  logic             wr_idx;
  logic             push, pop;
  logic             in_ready_d, out_valid_d;
  alu_entry_t       mem_q [2];
  alu_entry_t       push_entry;
  alu_entry_t       out_q, out_d;
  logic [WIDTH-1:0] core_result;
  logic             core_illegal;

  alu_core u_core (
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .result_c    (core_result),
    .illegal_c   (core_illegal)
  );

  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign push_entry = '{result: core_result, zero: (core_result == '0), illegal: core_illegal};
  assign out_q      = '{result: result, zero: zero, illegal: illegal};

  // Occupancy state register and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      head_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next occupancy, write slot and next head entry
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    wr_idx  = head_q;
    out_d   = out_q;

    case (state_q)
      EMPTY: begin
        wr_idx = head_q;
        if (push) state_d = ONE;
      end
      ONE: begin
        wr_idx = ~head_q;
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL: begin
        wr_idx = ~head_q;
        if (pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase

    if (pop) head_d = ~head_q;

    // The new head may be the entry being written this cycle, so it is
    // forwarded from the ALU rather than read back from the buffer.
    if (state_d != EMPTY) begin
      if (pop) out_d = (state_q == FULL) ? mem_q[~head_q] : push_entry;
      else     out_d = (state_q == EMPTY) ? push_entry : mem_q[head_q];
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // Buffer storage and registered head outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      result   <= '0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (push) mem_q[wr_idx] <= push_entry;
      result  <= out_d.result;
      zero    <= out_d.zero;
      illegal <= out_d.illegal;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_control = c;
    src_a       = a;
    src_b       = b;
  endtask

  initial begin
    logic [31:0] q[$];
    int          cnt;
    logic        acc;
    logic        pp;

    vecs[0]  = '{3'b000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0};
    vecs[2]  = '{3'b010, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
    vecs[5]  = '{3'b100, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
    vecs[6]  = '{3'b111, 32'd9,        32'd3,        32'd0,        1'b1, 1'b1};
    vecs[7]  = '{3'b000, 32'd1,        32'd2,        32'd3,        1'b0, 1'b0};
    vecs[8]  = '{3'b001, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[10] = '{3'b101, 32'd4,        32'd4,        32'd0,        1'b1, 1'b1};
    vecs[11] = '{3'b100, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    issue(3'b000, 32'd0, 32'd0);
    #12 rst_n = 1'b1;
    step();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);

    // Table-driven single operations, one-cycle latency then pop
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].ctl, vecs[i].a, vecs[i].b);
      in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
      in_valid = 1'b0;
      step();
      chk($sformatf("vec%0d_popped", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_hold", i), result, vecs[i].res);
    end

    // Backpressure: third op held upstream until space frees
    out_ready = 1'b0;
    in_valid  = 1'b1;
    issue(3'b000, 32'd1, 32'd1);
    step();
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    chk("bp_head_a", result, 32'd2);
    issue(3'b000, 32'd2, 32'd2);
    step();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_head_b", result, 32'd2);
    issue(3'b000, 32'd3, 32'd3);
    step();
    chk("bp_ready_stall", 32'(in_ready), 32'd0);
    chk("bp_head_c", result, 32'd2);
    issue(3'b000, 32'd100, 32'd100);
    step();
    chk("bp_ignored_ready", 32'(in_ready), 32'd0);
    chk("bp_ignored_head", result, 32'd2);
    issue(3'b000, 32'd3, 32'd3);
    out_ready = 1'b1;
    step();
    chk("bp_pop1_valid", 32'(out_valid), 32'd1);
    chk("bp_pop1_result", result, 32'd4);
    chk("bp_pop1_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_pop2_valid", 32'(out_valid), 32'd1);
    chk("bp_pop2_result", result, 32'd6);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_drained_hold", result, 32'd6);

    // Streaming with out_ready toggling each cycle, scoreboard ordered
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      issue(3'b000, 32'(i), 32'd100);
      in_valid  = 1'b1;
      out_ready = (i % 2) == 1;
      acc = in_valid && in_ready;
      pp  = out_valid && out_ready;
      if (pp) begin
        if (q.size() == 0) chk("stream_unexpected_pop", 32'd1, 32'd0);
        else chk($sformatf("stream_res%0d", i), result, q.pop_front());
      end
      if (acc) q.push_back(32'(i) + 32'd100);
      step();
      cnt = cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
      chk($sformatf("stream_in_ready%0d", i), 32'(in_ready), 32'(cnt != 2));
      chk($sformatf("stream_out_valid%0d", i), 32'(out_valid), 32'(cnt != 0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) begin
        if (q.size() == 0) chk("drain_unexpected", 32'd1, 32'd0);
        else chk($sformatf("drain_res%0d", i), result, q.pop_front());
      end
      step();
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Reset mid-traffic with two entries buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    issue(3'b000, 32'd10, 32'd20);
    step();
    issue(3'b000, 32'd30, 32'd1);
    step();
    chk("prerst_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    step();
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    issue(3'b000, 32'd2, 32'd3);
    step();
    chk("postrst_op_valid", 32'(out_valid), 32'd1);
    chk("postrst_op_result", result, 32'd5);
    in_valid = 1'b0;
    step();
    chk("postrst_op_popped", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
